text_buffer_writer: RTL and testbench

Writer side of the character buffer that the screen renderer reads through its ascii/readIndex port pair. It accepts a stream of 8-bit character codes over a valid/ready handshake and maintains a text cursor. It writes each character into the character RAM at index row*COLS+col, and handles control codes, line wrap, row recycling and full-screen clears. It sits between the CPU/serial output path and the write port of the dual-port character RAM.

---
 rtl/text_buffer_writer.sv | 167 ++++++++++++++++
 tb/tb_text_buffer_writer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/text_buffer_writer.sv
// Writer side of the character RAM: turns a stream of character codes into RAM writes,
// tracks the text cursor and performs full-screen and single-row clears.
module text_buffer_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        charIn,
  input  logic              charValid,
  output logic              charReady,
  output logic [ADDR_W-1:0] writeIndex,
  output logic [7:0]        writeData,
  output logic              writeEnable,
  output logic [6:0]        cursorCol,
  output logic [4:0]        cursorRow,
  output logic              busy
);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    CLEAR_LINE
  } state_t;

  localparam logic [7:0]        SPACE     = 8'h20;
  localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
  localparam logic [6:0]        COL_ONE   = 7'd1;
  localparam logic [4:0]        ROW_ONE   = 5'd1;
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   SCR_TOTAL = (ADDR_W + 1)'(COLS * ROWS);
  localparam logic [ADDR_W:0]   LINE_LEN  = (ADDR_W + 1)'(COLS);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

  state_t              r_state;
  logic [ADDR_W:0]     r_count;
  logic [6:0]          r_col;
  logic [4:0]          r_row;
  logic                r_we;
  logic [ADDR_W-1:0]   r_idx;
  logic [7:0]          r_data;

  state_t              w_nState;
  logic [ADDR_W:0]     w_nCount;
  logic [6:0]          w_nCol;
  logic [4:0]          w_nRow;
  logic                w_nWe;
  logic [ADDR_W-1:0]   w_nIdx;
  logic [7:0]          w_nData;

  logic [ADDR_W-1:0]   w_rowBase;
  logic [ADDR_W-1:0]   w_curIdx;
  logic [4:0]          w_rowInc;

  assign w_rowBase = ADDR_W'(r_row) * ADDR_W'(COLS);
  assign w_curIdx  = w_rowBase + ADDR_W'(r_col);
  assign w_rowInc  = (r_row == LAST_ROW) ? 5'd0 : r_row + ROW_ONE;

  // The counter runs one past the last index so the final write is visible
  // before the state returns to IDLE.
  always_comb begin
    w_nState = r_state;
    w_nCount = r_count;
    w_nCol   = r_col;
    w_nRow   = r_row;
    w_nWe    = 1'b0;
    w_nIdx   = r_idx;
    w_nData  = r_data;
    case (r_state)
      CLEAR: begin
        if (r_count == SCR_TOTAL) begin
          w_nState = IDLE;
          w_nCol   = 7'd0;
          w_nRow   = 5'd0;
        end else begin
          w_nWe    = 1'b1;
          w_nIdx   = r_count[ADDR_W-1:0];
          w_nData  = SPACE;
          w_nCount = r_count + CNT_ONE;
        end
      end
      CLEAR_LINE: begin
        if (r_count == LINE_LEN) begin
          w_nState = IDLE;
        end else begin
          w_nWe    = 1'b1;
          w_nIdx   = w_rowBase + r_count[ADDR_W-1:0];
          w_nData  = SPACE;
          w_nCount = r_count + CNT_ONE;
        end
      end
      IDLE: begin
        if (charValid) begin
          if (charIn >= 8'h20 && charIn <= 8'h7E) begin
            w_nWe   = 1'b1;
            w_nIdx  = w_curIdx;
            w_nData = charIn;
            if (r_col != LAST_COL) begin
              w_nCol = r_col + COL_ONE;
            end else begin
              w_nCol   = 7'd0;
              w_nRow   = w_rowInc;
              w_nState = CLEAR_LINE;
              w_nCount = '0;
            end
          end else begin
            case (charIn)
              8'h0A: begin
                w_nCol   = 7'd0;
                w_nRow   = w_rowInc;
                w_nState = CLEAR_LINE;
                w_nCount = '0;
              end
              8'h0D: w_nCol = 7'd0;
              8'h08: begin
                if (r_col != 7'd0) begin
                  w_nCol  = r_col - COL_ONE;
                  w_nWe   = 1'b1;
                  w_nIdx  = w_curIdx - IDX_ONE;
                  w_nData = SPACE;
                end
              end
              // Cursor keeps its position until the full clear completes.
              8'h0C: begin
                w_nState = CLEAR;
                w_nCount = '0;
              end
              default: ;
            endcase
          end
        end
      end
      default: w_nState = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CLEAR;
      r_count <= '0;
      r_col   <= 7'd0;
      r_row   <= 5'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_data  <= SPACE;
    end else begin
      r_state <= w_nState;
      r_count <= w_nCount;
      r_col   <= w_nCol;
      r_row   <= w_nRow;
      r_we    <= w_nWe;
      r_idx   <= w_nIdx;
      r_data  <= w_nData;
    end
  end

  assign charReady   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign writeEnable = r_we;
  assign writeIndex  = r_idx;
  assign writeData   = r_data;
  assign cursorCol   = r_col;
  assign cursorRow   = r_row;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed bench for text_buffer_writer: clears, printable writes, control codes,
// row recycling and reset in the middle of a row clear.
module tb_text_buffer_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 14;

  logic              clk;
  logic              rst;
  logic [7:0]        charIn;
  logic              charValid;
  logic              charReady;
  logic [ADDR_W-1:0] writeIndex;
  logic [7:0]        writeData;
  logic              writeEnable;
  logic [6:0]        cursorCol;
  logic [4:0]        cursorRow;
  logic              busy;

  int checks = 0;
  int errors = 0;

  text_buffer_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .charIn(charIn), .charValid(charValid),
    .charReady(charReady), .writeIndex(writeIndex), .writeData(writeData),
    .writeEnable(writeEnable), .cursorCol(cursorCol), .cursorRow(cursorRow),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offers one character across the next rising edge; returns at the following negedge.
  task automatic applyStimulus(input logic [7:0] c);
    charIn    = c;
    charValid = 1'b1;
    @(negedge clk);
    charValid = 1'b0;
  endtask

  task automatic checkCursor(input string tag, input int col, input int row);
    checkOutput(tag, {cursorRow, cursorCol}, {5'(row), 7'(col)});
  endtask

  // Expects n consecutive space writes starting at base with charReady low.
  task automatic expectClear(input string tag, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput(tag, {charReady, writeEnable, writeIndex, writeData},
                  {1'b0, 1'b1, 14'(base + i), 8'h20});
    end
  endtask

  task automatic waitReady(input int limit);
    int cnt = 0;
    while (!charReady && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
    if (!charReady) checkOutput("readyTimeout", {31'd0, charReady}, 32'd1);
  endtask

  task automatic expectIdleNoWrite(input string tag, input int col, input int row);
    checkOutput({tag, "_we"}, {31'd0, writeEnable}, 32'd0);
    checkOutput({tag, "_ready"}, {30'd0, charReady, busy}, {30'd0, 1'b1, 1'b0});
    checkCursor({tag, "_cursor"}, col, row);
  endtask

  initial begin
    rst       = 1'b0;
    charIn    = 8'h00;
    charValid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", {charReady, busy, writeEnable, writeIndex, writeData},
                {1'b0, 1'b1, 1'b0, 14'd0, 8'h20});
    checkCursor("resetCursor", 0, 0);
    rst = 1'b1;

    $display("[TB] power-up clear");
    expectClear("powerClear", 0, COLS * ROWS);
    @(negedge clk);
    expectIdleNoWrite("afterPowerClear", 0, 0);

    $display("[TB] back-to-back printable");
    applyStimulus(8'h48);
    checkOutput("writeH", {charReady, writeEnable, writeIndex, writeData}, {1'b1, 1'b1, 14'd0, 8'h48});
    applyStimulus(8'h69);
    checkOutput("writeI", {charReady, writeEnable, writeIndex, writeData}, {1'b1, 1'b1, 14'd1, 8'h69});
    checkCursor("cursorHi", 2, 0);

    for (int i = 0; i < 77; i++) applyStimulus(8'h61);
    checkOutput("writeCol78", {writeEnable, writeIndex, writeData}, {1'b1, 14'd78, 8'h61});
    checkCursor("cursorCol79", 79, 0);

    $display("[TB] line wrap at last column");
    applyStimulus(8'h5A);
    checkOutput("writeZ", {charReady, writeEnable, writeIndex, writeData}, {1'b0, 1'b1, 14'd79, 8'h5A});
    checkCursor("cursorAfterWrap", 0, 1);
    expectClear("wrapLineClear", 80, COLS);
    @(negedge clk);
    expectIdleNoWrite("afterWrapClear", 0, 1);

    $display("[TB] row recycling on LF from last row");
    for (int r = 0; r < 28; r++) begin
      applyStimulus(8'h0A);
      waitReady(200);
    end
    checkCursor("cursorRow29", 0, 29);
    for (int i = 0; i < 10; i++) applyStimulus(8'h62);
    checkCursor("cursorCol10Row29", 10, 29);
    applyStimulus(8'h0A);
    checkOutput("lfNoWrite", {charReady, writeEnable}, {1'b0, 1'b0});
    checkCursor("cursorAfterRecycle", 0, 0);
    expectClear("recycleClear", 0, COLS);
    @(negedge clk);
    expectIdleNoWrite("afterRecycle", 0, 0);

    $display("[TB] backspace, CR and ignored codes");
    for (int r = 0; r < 3; r++) begin
      applyStimulus(8'h0A);
      waitReady(200);
    end
    for (int i = 0; i < 5; i++) applyStimulus(8'h63);
    checkCursor("cursorCol5Row3", 5, 3);
    applyStimulus(8'h08);
    checkOutput("bsWrite", {charReady, writeEnable, writeIndex, writeData}, {1'b1, 1'b1, 14'd244, 8'h20});
    checkCursor("cursorAfterBs", 4, 3);
    applyStimulus(8'h0D);
    expectIdleNoWrite("crFromCol4", 0, 3);
    applyStimulus(8'h08);
    expectIdleNoWrite("bsAtCol0", 0, 3);
    for (int i = 0; i < 7; i++) applyStimulus(8'h64);
    checkCursor("cursorCol7Row3", 7, 3);
    applyStimulus(8'h0D);
    expectIdleNoWrite("crFromCol7", 0, 3);
    applyStimulus(8'h07);
    expectIdleNoWrite("bellIgnored", 0, 3);

    $display("[TB] reset in the middle of a row clear");
    applyStimulus(8'h0A);
    checkCursor("cursorRow4", 0, 4);
    expectClear("partialLineClear", 320, 40);
    rst = 1'b0;
    #1;
    checkOutput("midReset", {charReady, busy, writeEnable, writeIndex, writeData},
                {1'b0, 1'b1, 1'b0, 14'd0, 8'h20});
    checkCursor("midResetCursor", 0, 0);
    @(negedge clk);
    rst = 1'b1;
    expectClear("reClear", 0, COLS * ROWS);
    @(negedge clk);
    expectIdleNoWrite("afterReClear", 0, 0);

    $display("[TB] form feed");
    applyStimulus(8'h65);
    checkCursor("cursorBeforeFf", 1, 0);
    applyStimulus(8'h0C);
    checkOutput("ffStart", {charReady, busy, writeEnable}, {1'b0, 1'b1, 1'b0});
    checkCursor("cursorDuringFf", 1, 0);
    expectClear("ffClear", 0, COLS * ROWS);
    @(negedge clk);
    expectIdleNoWrite("afterFf", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
